// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer-state encoding and response classification.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } e_state;

   // How a transfer ended; anything other than RSP_OKAY is reported as an error.
   typedef enum logic [1:0] {
      RSP_OKAY    = 2'd0,
      RSP_SLVERR  = 2'd1,
      RSP_TIMEOUT = 2'd2
   } e_rsp;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or above ptr.
module rr_arbiter #(
   parameter int unsigned N  = 2,
   parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  grant
);

   logic          found;
   logic [PW-1:0] idx;

   // Scan upward from ptr with wrap-around; first active request wins.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N; i++) begin
         idx = PW'((32'(ptr) + i) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin sharing of one APB3 master port between NUM_REQ requesters,
// with a wait-state timeout so a stuck slave cannot hang the bus.
module apb_req_arbiter
   import apb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                          PCLK,
   input  logic                          PRESETn,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          rsp_err,
   output logic                          PSELx,
   output logic                          PENABLE,
   output logic                          PWRITE,
   output logic [ADDR_WIDTH-1:0]         PADDR,
   output logic [DATA_WIDTH-1:0]         PWDATA,
   input  logic [DATA_WIDTH-1:0]         PRDATA,
   input  logic                          PREADY,
   input  logic                          PSLVERR
);

   localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // The abort fires on the edge where the incremented count would reach TIMEOUT.
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   e_state               state_q, state_d;
   logic [PW-1:0]        ptr_q, ptr_d;
   logic [NUM_REQ-1:0]   owner_q;
   logic [CW-1:0]        cnt_q;
   logic [NUM_REQ-1:0]   grant;
   logic [PW-1:0]        win_idx;
   logic                 accept;
   logic                 timeout_hit;
   logic                 done;
   e_rsp                 rsp_kind;

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr_arbiter (
      .req   (req_valid),
      .ptr   (ptr_q),
      .grant (grant)
   );

   assign accept      = (state_q == IDLE) && (|req_valid);
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
   assign req_ready   = (PRESETn && state_q == IDLE) ? grant : '0;
   assign PSELx       = (state_q != IDLE);
   assign PENABLE     = (state_q == ACCESS);

   // Encode the one-hot grant and advance the pointer past the winner.
   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) win_idx = PW'(i);
      end
      ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
   end

   // Transfer completion (PREADY beats the timeout) and next-state logic.
   always_comb begin
      done     = 1'b0;
      rsp_kind = RSP_OKAY;
      state_d  = state_q;
      unique case (state_q)
         IDLE:   if (accept) state_d = SETUP;
         SETUP:  state_d = ACCESS;
         ACCESS: begin
            if (PREADY) begin
               done     = 1'b1;
               rsp_kind = PSLVERR ? RSP_SLVERR : RSP_OKAY;
            end else if (timeout_hit) begin
               done     = 1'b1;
               rsp_kind = RSP_TIMEOUT;
            end
            if (done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Latch the winner's payload onto the bus; held until the next accept.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ptr_q   <= '0;
         owner_q <= '0;
         PWRITE  <= 1'b0;
         PADDR   <= '0;
         PWDATA  <= '0;
      end else if (accept) begin
         ptr_q   <= ptr_d;
         owner_q <= grant;
         PWRITE  <= req_write[win_idx];
         PADDR   <= req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
         PWDATA  <= req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Wait-state counter: cleared entering SETUP, counts ACCESS cycles with PREADY low.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn)                    cnt_q <= '0;
      else if (accept)                 cnt_q <= '0;
      else if (state_q == ACCESS && !PREADY) cnt_q <= cnt_q + 1'b1;
   end

   // One-cycle response pulse to the owner; data/err hold until the next response.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         rsp_valid <= '0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         rsp_valid <= done ? owner_q : '0;
         if (done) begin
            rsp_rdata <= (rsp_kind == RSP_TIMEOUT || PWRITE) ? '0 : PRDATA;
            rsp_err   <= (rsp_kind != RSP_OKAY);
         end
      end
   end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter: vector table of single transfers plus
// hand-written sequences for contention, timeout and mid-transfer reset.
module tb_apb_req_arbiter;

   logic        PCLK;
   logic        PRESETn;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_write;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        PSELx, PENABLE, PWRITE;
   logic [3:0]  PADDR;
   logic [7:0]  PWDATA;
   logic [7:0]  PRDATA;
   logic        PREADY, PSLVERR;

   int n_checks = 0;
   int n_err    = 0;

   apb_req_arbiter #(
      .NUM_REQ    (2),
      .DATA_WIDTH (8),
      .ADDR_WIDTH (4),
      .TIMEOUT    (16)
   ) dut (
      .PCLK      (PCLK),
      .PRESETn   (PRESETn),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .PSELx     (PSELx),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PADDR     (PADDR),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   typedef struct {
      int         r;
      logic       wr;
      logic [3:0] addr;
      logic [7:0] wdata;
      int         waits;
      logic [7:0] prdata;
      logic       slverr;
      logic [7:0] exp_rdata;
      logic       exp_err;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after a negedge with the DUT in IDLE; returns just after a negedge in IDLE.
   task automatic run_xfer(input vec_t v);
      logic [1:0] oh;
      oh = '0;
      oh[v.r] = 1'b1;
      req_valid = oh;
      req_write[v.r] = v.wr;
      req_addr[v.r*4 +: 4] = v.addr;
      req_wdata[v.r*8 +: 8] = v.wdata;
      PREADY = 1'b0;
      PSLVERR = 1'b0;
      PRDATA = ~v.prdata;
      #1 check("xfer_ready", req_ready, oh);
      @(posedge PCLK);
      #1 req_valid = '0;
      for (int cyc = 1; cyc <= 2 + v.waits; cyc++) begin
         @(negedge PCLK);
         check("xfer_sel_en", {PSELx, PENABLE}, {1'b1, cyc >= 2});
         check("xfer_paddr", PADDR, v.addr);
         check("xfer_pwrite", PWRITE, v.wr);
         check("xfer_pwdata", PWDATA, v.wdata);
         check("xfer_no_rsp", rsp_valid, 2'b00);
         if (cyc >= 2 && cyc == 2 + v.waits) begin
            PREADY = 1'b1;
            PRDATA = v.prdata;
            PSLVERR = v.slverr;
         end
      end
      @(negedge PCLK);
      PREADY = 1'b0;
      PSLVERR = 1'b0;
      check("xfer_rsp_valid", rsp_valid, oh);
      check("xfer_rsp_rdata", rsp_rdata, v.exp_rdata);
      check("xfer_rsp_err", rsp_err, v.exp_err);
      check("xfer_idle_sel", {PSELx, PENABLE}, 2'b00);
      check("xfer_idle_paddr", PADDR, v.addr);
      @(negedge PCLK);
      check("xfer_rsp_pulse", rsp_valid, 2'b00);
   endtask

   initial begin
      vec_t v;
      logic [1:0] exp_rdy;
      logic [1:0] exp_rsp;

      //          r  wr    addr  wdata  waits prdata slverr exp_rdata exp_err
      vecs[0] = '{0, 1'b1, 4'h3, 8'hA5, 0,    8'h77, 1'b0,  8'h00,    1'b0};
      vecs[1] = '{1, 1'b0, 4'hC, 8'h00, 2,    8'h5E, 1'b0,  8'h5E,    1'b0};
      vecs[2] = '{0, 1'b0, 4'h7, 8'h12, 1,    8'hC3, 1'b1,  8'hC3,    1'b1};
      vecs[3] = '{1, 1'b1, 4'h9, 8'h3C, 0,    8'h11, 1'b1,  8'h00,    1'b1};
      vecs[4] = '{0, 1'b0, 4'hF, 8'h00, 3,    8'h81, 1'b0,  8'h81,    1'b0};
      // PREADY lands on the same edge the timeout would fire: normal completion.
      vecs[5] = '{1, 1'b0, 4'h5, 8'h00, 15,   8'h6A, 1'b0,  8'h6A,    1'b0};

      PRESETn = 1'b0;
      req_valid = 2'b01;
      req_write = '0;
      req_addr = '0;
      req_wdata = '0;
      PRDATA = '0;
      PREADY = 1'b0;
      PSLVERR = 1'b0;

      // Reset values, including req_ready suppressed while in reset.
      #12;
      check("rst_ready", req_ready, 2'b00);
      check("rst_apb", {PSELx, PENABLE, PWRITE, PADDR, PWDATA}, 15'd0);
      check("rst_rsp", {rsp_valid, rsp_rdata, rsp_err}, 11'd0);
      @(negedge PCLK);
      PRESETn = 1'b1;
      req_valid = '0;

      for (int i = 0; i < 6; i++) run_xfer(vecs[i]);

      // Contention: both hold valid, zero-wait writes, first one errors.
      req_valid = 2'b11;
      req_write = 2'b11;
      PREADY = 1'b1;
      PSLVERR = 1'b1;
      for (int cyc = 0; cyc <= 12; cyc++) begin
         if (cyc > 0) @(negedge PCLK);
         if (cyc == 12) req_valid = '0;
         #1;
         exp_rdy = '0;
         if (cyc % 3 == 0 && cyc < 12) exp_rdy = ((cyc / 3) % 2 == 1) ? 2'b10 : 2'b01;
         check("rr_ready", req_ready, exp_rdy);
         exp_rsp = '0;
         if (cyc % 3 == 0 && cyc > 0) exp_rsp = (((cyc - 3) / 3) % 2 == 1) ? 2'b10 : 2'b01;
         check("rr_rsp_valid", rsp_valid, exp_rsp);
         if (cyc % 3 == 0 && cyc > 0) check("rr_rsp_err", rsp_err, cyc == 3);
         if (cyc == 3) PSLVERR = 1'b0;
      end
      @(negedge PCLK);
      PREADY = 1'b0;

      // Timeout: slave never ready, abort after 16 waiting ACCESS cycles.
      req_valid = 2'b01;
      req_write[0] = 1'b0;
      req_addr[3:0] = 4'h2;
      PRDATA = 8'hFF;
      #1 check("to_ready", req_ready, 2'b01);
      @(posedge PCLK);
      #1 req_valid = '0;
      for (int cyc = 1; cyc <= 17; cyc++) begin
         @(negedge PCLK);
         check("to_sel_en", {PSELx, PENABLE}, {1'b1, cyc >= 2});
         check("to_no_rsp", rsp_valid, 2'b00);
      end
      check("to_paddr", PADDR, 4'h2);
      @(negedge PCLK);
      check("to_rsp_valid", rsp_valid, 2'b01);
      check("to_rsp_err", rsp_err, 1'b1);
      check("to_rsp_rdata", rsp_rdata, 8'h00);
      check("to_sel_en_drop", {PSELx, PENABLE}, 2'b00);
      @(negedge PCLK);
      v = '{1, 1'b0, 4'hA, 8'h00, 1, 8'h42, 1'b0, 8'h42, 1'b0};
      run_xfer(v);

      // Reset in the middle of ACCESS after requester 0 won (pointer at 1).
      req_valid = 2'b01;
      req_write[0] = 1'b1;
      req_addr[3:0] = 4'h6;
      req_wdata[7:0] = 8'h99;
      @(posedge PCLK);
      #1 req_valid = '0;
      @(negedge PCLK);
      @(negedge PCLK);
      check("rst_mid_in_access", {PSELx, PENABLE}, 2'b11);
      #2;
      PRESETn = 1'b0;
      req_valid = 2'b11;
      #1;
      check("rst_mid_apb", {PSELx, PENABLE, PWRITE, PADDR, PWDATA}, 15'd0);
      check("rst_mid_rsp", {rsp_valid, rsp_rdata, rsp_err}, 11'd0);
      check("rst_mid_ready", req_ready, 2'b00);
      @(negedge PCLK);
      PRESETn = 1'b1;
      PREADY = 1'b1;
      #1 check("rst_next_grant", req_ready, 2'b01);
      req_valid = '0;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge PCLK);
         check("rst_no_rsp", rsp_valid, 2'b00);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Shares one APB3 master port between `NUM_REQ` local requesters using round-robin arbitration. It sequences each granted request through the APB IDLE → SETUP → ACCESS protocol and returns read data or error status to the winning requester. A wait-state timeout prevents a slave that never raises `PREADY` from hanging the bus. The block sits between requester logic and the APB interconnect, and drives the bus directly.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `DATA_WIDTH`, 8: `PWDATA`/`PRDATA` width.
- `ADDR_WIDTH`, 4: `PADDR` width.
- `TIMEOUT`, 16: maximum `ACCESS` cycles with `PREADY` low; 0 disables the timeout.

Ports:
- `PCLK`  in  1  clock, rising edge.
- `PRESETn`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  one-hot accept.
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses slice i.
- `req_wdata`  in  NUM_REQ*DATA_WIDTH  packed write data.
- `rsp_valid`  out  NUM_REQ  one-hot, one-cycle response pulse.
- `rsp_rdata`  out  DATA_WIDTH  read data, shared by all requesters.
- `rsp_err`  out  1  `PSLVERR` or timeout, qualified by `rsp_valid`.
- `PSELx`, `PENABLE`, `PWRITE`  out  1  APB control.
- `PADDR`  out  ADDR_WIDTH.
- `PWDATA`  out  DATA_WIDTH.
- `PRDATA`  in  DATA_WIDTH.
- `PREADY`, `PSLVERR`  in  1.

## Operation
- States: `IDLE`, `SETUP`, `ACCESS`. Reset enters `IDLE`.
- `IDLE`:
  - If any `req_valid` is high, the round-robin arbiter picks winner w, searching upward from pointer p with wrap-around.
  - `req_ready[w]` is high combinationally in that cycle only.
  - On the edge, the block registers w, `req_write[w]`, `req_addr[w]` and `req_wdata[w]` into the APB outputs, sets p = (w+1) mod NUM_REQ, and moves to `SETUP`.
  - If no request is pending, the block stays in `IDLE` and p is unchanged.
- `SETUP`: `PSELx`=1, `PENABLE`=0. Always moves to `ACCESS` next.
- `ACCESS`: `PSELx`=1, `PENABLE`=1.
  - If `PREADY`=1: capture the response and move to `IDLE`.
  - Otherwise: increment the wait counter.
  - If the counter reaches `TIMEOUT` (when `TIMEOUT` ≠ 0): abort the transfer, move to `IDLE`, and flag a timeout.
- Response, registered, on the edge that leaves `ACCESS`:
  - `rsp_valid[w]`=1 for one cycle.
  - `rsp_rdata` = `PRDATA` for a read; 0 for a write or a timeout.
  - `rsp_err` = `PSLVERR` for a normal completion; 1 for a timeout.
- `PADDR`, `PWRITE` and `PWDATA` hold stable from `SETUP` through the end of `ACCESS`, and keep their values in `IDLE`.
- The wait counter has width `$clog2(TIMEOUT+1)` (minimum 1) and clears on entry to `SETUP`.
- A requester must hold `req_valid` and its payload until it sees `req_ready`. `req_valid` dropping before grant is legal; that requester is simply not selected.
- Requests are not accepted while a transfer is in progress. A new request from the requester whose response is in flight competes normally in the next `IDLE` cycle.

## Timing
- Reset values:
  - `PSELx`, `PENABLE`, `PWRITE`, `PADDR`, `PWDATA` = 0.
  - `rsp_valid`, `rsp_rdata`, `rsp_err` = 0.
  - Arbitration pointer p = 0, wait counter = 0.
- `req_ready` is forced to 0 while `PRESETn` is low.
- Zero-wait transfer: accept at edge 0, `SETUP` in cycle 1, `ACCESS` in cycle 2. `PREADY` is sampled at edge 3, where `rsp_valid` rises. One mandatory `IDLE` cycle follows before the next `SETUP`.
- Minimum accept-to-accept spacing is 3 cycles.
- With k wait states, the response arrives at edge 3+k.
- The timeout response arrives at edge 2+`TIMEOUT`. `PSELx` and `PENABLE` drop on that edge.
- Reset asserted mid-transfer: all outputs go to reset values immediately and asynchronously. No `rsp_valid` is issued for the aborted transfer.
- `PREADY` asserted on the same edge the counter reaches `TIMEOUT`: `PREADY` wins, and the result is a normal completion.

## Structure
- Package `apb_pkg`: `e_state` enum (`IDLE`, `SETUP`, `ACCESS`, 2-bit) and the response-type constants. This package is shared with the other APB blocks.
- Sub-module `rr_arbiter` (parameter N). Inputs: `req`, pointer. Output: one-hot `grant`. It is purely combinational; the pointer register lives in the top module.

## Test plan
- Single write from requester 0 (addr 0x3, data 0xA5), `PREADY` tied high → `PSELx` high for 2 cycles, `PENABLE` high 1 cycle, `rsp_valid[0]` at edge 3, `rsp_err`=0, `rsp_rdata`=0.
- Read from requester 1 (addr 0xC) with 2 wait states, `PRDATA`=0x5E → `rsp_valid[1]` at edge 5, `rsp_rdata`=0x5E, `PADDR` stable at 0xC throughout.
- Both requesters hold `req_valid` continuously for 4 transfers → grant order 0, 1, 0, 1, with each accept spaced 3 cycles apart.
- `PREADY` held low, `TIMEOUT`=16 → abort at edge 18, `rsp_err`=1, `rsp_rdata`=0, `PSELx`=0. Next request proceeds normally.
- `PSLVERR`=1 with `PREADY`=1 on a write → `rsp_err`=1. Round-robin order is unaffected.
- `PRESETn` pulsed low during `ACCESS` → all outputs 0 immediately, no `rsp_valid`, and the next grant goes to requester 0.
